// File: rtl/bbox_pkg.sv
// Types and ratio constants shared by the bounding-box stage and the shape classifier.
package bbox_pkg;

    typedef enum logic [1:0] {
        SHAPE_NONE     = 2'd0,
        SHAPE_SQUARE   = 2'd1,
        SHAPE_CIRCLE   = 2'd2,
        SHAPE_TRIANGLE = 2'd3
    } shape_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_CLASSIFY = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam logic [18:0] RATIO_SCALE  = 19'd16;
    localparam logic [18:0] RATIO_SQUARE = 19'd14;
    localparam logic [18:0] RATIO_CIRCLE = 19'd10;

    // Fill ratio fg/area against 14/16 and 10/16; an empty box has no shape.
    function automatic shape_e classify_shape(input logic [14:0] fg, input logic [14:0] area);
        logic [18:0] fg_scaled;
        logic [18:0] area_w;
        shape_e      result;
        fg_scaled = {4'd0, fg} * RATIO_SCALE;
        area_w    = {4'd0, area};
        if (area == 15'd0) begin
            result = SHAPE_NONE;
        end else if (fg_scaled >= area_w * RATIO_SQUARE) begin
            result = SHAPE_SQUARE;
        end else if (fg_scaled >= area_w * RATIO_CIRCLE) begin
            result = SHAPE_CIRCLE;
        end else begin
            result = SHAPE_TRIANGLE;
        end
        return result;
    endfunction

endpackage

// File: rtl/bbox_raster_counter.sv
// Raster walker over a bounding box: x fastest, exposes the next coordinate and a last flag.
module bbox_raster_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    input  logic [6:0] load_x,
    input  logic [6:0] load_y,
    input  logic [6:0] x_min,
    input  logic [6:0] x_max,
    input  logic [6:0] y_max,
    output logic [6:0] x_next,
    output logic [6:0] y_next,
    output logic       last
);

    logic [6:0] x_r;
    logic [6:0] y_r;

    assign last = (x_r == x_max) && (y_r == y_max);

    // Successor coordinate: wrap to the row start when the right edge is reached.
    always_comb begin
        x_next = x_r;
        y_next = y_r;
        if (x_r == x_max) begin
            x_next = x_min;
            y_next = y_r + 7'd1;
        end else begin
            x_next = x_r + 7'd1;
            y_next = y_r;
        end
    end

    // Coordinate register; holds at the final pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= 7'd0;
            y_r <= 7'd0;
        end else if (load) begin
            x_r <= load_x;
            y_r <= load_y;
        end else if (advance && !last) begin
            x_r <= x_next;
            y_r <= y_next;
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

endmodule

// File: rtl/bbox_shape_classifier.sv
// Scans a bounding box of the image RAM, counts dark pixels and classifies the fill ratio.
module bbox_shape_classifier
    import bbox_pkg::*;
#(
    parameter int         IMG_W     = 128,
    parameter int         IMG_H     = 128,
    parameter logic [7:0] THRESHOLD = 8'd128
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  xMin,
    input  logic [6:0]  yMin,
    input  logic [6:0]  xMax,
    input  logic [6:0]  yMax,
    output logic [13:0] ram_addr,
    input  logic [7:0]  ram_q,
    output logic        busy,
    output logic        done,
    output logic [14:0] fg_count,
    output logic [1:0]  shape,
    output logic [14:0] area
);

    localparam logic [13:0] ROW_STRIDE = 14'(IMG_W);

    function automatic logic [13:0] pix_addr(input logic [6:0] px, input logic [6:0] py);
        return ({7'd0, py} * ROW_STRIDE) + {7'd0, px};
    endfunction

    state_e      state_r;
    state_e      state_next_s;
    shape_e      shape_r;
    logic [6:0]  x_min_r, x_max_r, y_max_r;
    logic [6:0]  x_next_s, y_next_s;
    logic        last_s, accept_s, box_valid_s, rd_valid_r, dark_s;
    logic [7:0]  box_w_s, box_h_s;
    logic [14:0] area_s, area_r, fg_count_r;
    logic [13:0] ram_addr_r;
    logic        busy_r, done_r;

    assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign dark_s   = rd_valid_r && (ram_q < THRESHOLD);

    // Box geometry; boxes that are inverted or outside the image are empty.
    always_comb begin
        box_w_s     = {1'b0, xMax} - {1'b0, xMin} + 8'd1;
        box_h_s     = {1'b0, yMax} - {1'b0, yMin} + 8'd1;
        box_valid_s = (xMax >= xMin) && (yMax >= yMin)
                      && (int'(xMax) < IMG_W) && (int'(yMax) < IMG_H);
        if (box_valid_s) begin
            area_s = {7'd0, box_w_s} * {7'd0, box_h_s};
        end else begin
            area_s = 15'd0;
        end
    end

    bbox_raster_counter u_raster (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .load    (accept_s),
        .advance (state_r == ST_SCAN),
        .load_x  (xMin),
        .load_y  (yMin),
        .x_min   (x_min_r),
        .x_max   (x_max_r),
        .y_max   (y_max_r),
        .x_next  (x_next_s),
        .y_next  (y_next_s),
        .last    (last_s)
    );

    // State register.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start is only honoured while idle or holding a result.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (box_valid_s) begin
                        state_next_s = ST_SCAN;
                    end else begin
                        state_next_s = ST_CLASSIFY;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_SCAN: begin
                if (last_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_SCAN;
                end
            end
            ST_DRAIN:    state_next_s = ST_CLASSIFY;
            ST_CLASSIFY: state_next_s = ST_DONE;
            default:     state_next_s = ST_IDLE;
        endcase
    end

    // Datapath: address issue, one-cycle-delayed sample counting, result registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            x_min_r    <= 7'd0;
            x_max_r    <= 7'd0;
            y_max_r    <= 7'd0;
            area_r     <= 15'd0;
            fg_count_r <= 15'd0;
            shape_r    <= SHAPE_NONE;
            ram_addr_r <= 14'd0;
            rd_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            rd_valid_r <= (state_r == ST_SCAN);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_min_r    <= xMin;
                        x_max_r    <= xMax;
                        y_max_r    <= yMax;
                        area_r     <= area_s;
                        fg_count_r <= 15'd0;
                        shape_r    <= SHAPE_NONE;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                        ram_addr_r <= box_valid_s ? pix_addr(xMin, yMin) : 14'd0;
                    end else begin
                        ram_addr_r <= 14'd0;
                    end
                end
                ST_SCAN: begin
                    ram_addr_r <= last_s ? 14'd0 : pix_addr(x_next_s, y_next_s);
                    if (dark_s) begin
                        fg_count_r <= fg_count_r + 15'd1;
                    end else begin
                        fg_count_r <= fg_count_r;
                    end
                end
                ST_DRAIN: begin
                    ram_addr_r <= 14'd0;
                    if (dark_s) begin
                        fg_count_r <= fg_count_r + 15'd1;
                    end else begin
                        fg_count_r <= fg_count_r;
                    end
                end
                ST_CLASSIFY: begin
                    ram_addr_r <= 14'd0;
                    shape_r    <= classify_shape(fg_count_r, area_r);
                    busy_r     <= 1'b0;
                    done_r     <= 1'b1;
                end
                default: begin
                    ram_addr_r <= 14'd0;
                end
            endcase
        end
    end

    assign ram_addr = ram_addr_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign fg_count = fg_count_r;
    assign area     = area_r;
    assign shape    = shape_r;

endmodule

// File: tb/tb_bbox_shape_classifier.sv
// Directed bench: image RAM model plus a box-level reference model checked every cycle.
module tb_bbox_shape_classifier;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  xMin, yMin, xMax, yMax;
    logic [13:0] ram_addr;
    logic [7:0]  ram_q;
    logic        busy, done;
    logic [14:0] fg_count, area;
    logic [1:0]  shape;

    bbox_shape_classifier dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .start    (start),
        .xMin     (xMin),
        .yMin     (yMin),
        .xMax     (xMax),
        .yMax     (yMax),
        .ram_addr (ram_addr),
        .ram_q    (ram_q),
        .busy     (busy),
        .done     (done),
        .fg_count (fg_count),
        .shape    (shape),
        .area     (area)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [7:0] img [0:16383];
    always @(posedge CLOCK_50) ram_q <= img[ram_addr];

    int checks = 0;
    int errors = 0;
    int hits_last_pix = 0;
    always @(negedge CLOCK_50) if (ram_addr == 14'd16383) hits_last_pix++;

    // Reference model of one classification.
    bit m_valid;
    int m_n, m_fg, m_area, m_shape;
    int m_addrs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_box(input int x0, input int y0, input int x1, input int y1);
        m_addrs.delete();
        m_fg    = 0;
        m_valid = (x1 >= x0) && (y1 >= y0);
        if (m_valid) begin
            for (int y = y0; y <= y1; y++)
                for (int x = x0; x <= x1; x++) begin
                    m_addrs.push_back(y * 128 + x);
                    if (img[y * 128 + x] < 8'd128) m_fg++;
                end
        end
        m_n    = m_addrs.size();
        m_area = m_n;
        if (!m_valid)                 m_shape = 0;
        else if (m_fg * 8 >= m_area * 7) m_shape = 1;
        else if (m_fg * 8 >= m_area * 5) m_shape = 2;
        else                          m_shape = 3;
    endtask

    // k = cycles elapsed since the clock edge that accepted start.
    task automatic check_cycle(input int k);
        bit eb;
        int ea;
        eb = m_valid ? (k <= m_n + 2) : (k <= 1);
        ea = (m_valid && k <= m_n) ? m_addrs[k - 1] : 0;
        chk("busy", int'(busy), int'(eb));
        chk("done", int'(done), int'(!eb));
        chk("ram_addr", int'(ram_addr), ea);
        if (!eb) begin
            chk("fg_count", int'(fg_count), m_fg);
            chk("area", int'(area), m_area);
            chk("shape", int'(shape), m_shape);
        end
    endtask

    task automatic paint(input int x0, input int y0, input int x1, input int y1, input int ndark);
        int c;
        c = 0;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                img[y * 128 + x] = (c < ndark) ? 8'd127 : 8'd128;
                c++;
            end
    endtask

    task automatic run_box(input int x0, input int y0, input int x1, input int y1, input int dup_at);
        int last_k;
        model_box(x0, y0, x1, y1);
        @(negedge CLOCK_50);
        xMin  = 7'(x0);
        yMin  = 7'(y0);
        xMax  = 7'(x1);
        yMax  = 7'(y1);
        start = 1'b1;
        last_k = m_valid ? m_n + 5 : 4;
        for (int k = 1; k <= last_k; k++) begin
            @(negedge CLOCK_50);
            if (k == 1 || k == dup_at + 1) start = 1'b0;
            if (k == dup_at) begin
                start = 1'b1;
                xMin = 7'd0; yMin = 7'd0; xMax = 7'd1; yMax = 7'd1;
            end
            check_cycle(k);
        end
    endtask

    int dark_tbl [4] = '{10, 9, 14, 13};
    int shape_tbl[4] = '{2, 3, 1, 2};

    initial begin
        for (int i = 0; i < 16384; i++) img[i] = 8'd200;
        rst_n = 1'b0;
        start = 1'b0;
        xMin = 7'd0; yMin = 7'd0; xMax = 7'd0; yMax = 7'd0;
        repeat (2) @(negedge CLOCK_50);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fg", int'(fg_count), 0);
        chk("rst_area", int'(area), 0);
        chk("rst_shape", int'(shape), 0);
        chk("rst_addr", int'(ram_addr), 0);
        rst_n = 1'b1;
        @(negedge CLOCK_50);

        // Fully dark 52x37 box.
        paint(28, 29, 79, 65, 1924);
        run_box(28, 29, 79, 65, 0);
        chk("lit_fill_fg", int'(fg_count), 1924);
        chk("lit_fill_area", int'(area), 1924);
        chk("lit_fill_shape", int'(shape), 1);

        // Ratio boundaries on a 4x4 box, including 127/128 threshold edge values.
        for (int t = 0; t < 4; t++) begin
            paint(0, 0, 3, 3, dark_tbl[t]);
            run_box(0, 0, 3, 3, 0);
            chk("lit_ratio_fg", int'(fg_count), dark_tbl[t]);
            chk("lit_ratio_shape", int'(shape), shape_tbl[t]);
        end

        // Inverted box.
        run_box(20, 0, 10, 5, 0);
        chk("lit_inv_area", int'(area), 0);
        chk("lit_inv_shape", int'(shape), 0);

        // Start pulse with a different box mid-scan must be ignored.
        paint(0, 0, 7, 7, 20);
        run_box(0, 0, 7, 7, 5);
        chk("lit_dup_fg", int'(fg_count), 20);
        chk("lit_dup_area", int'(area), 64);
        chk("lit_dup_shape", int'(shape), 3);

        // Reset in the middle of a scan.
        paint(40, 40, 49, 49, 100);
        @(negedge CLOCK_50);
        xMin = 7'd40; yMin = 7'd40; xMax = 7'd49; yMax = 7'd49;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_fg", int'(fg_count), 0);
        chk("mid_rst_area", int'(area), 0);
        chk("mid_rst_shape", int'(shape), 0);
        chk("mid_rst_addr", int'(ram_addr), 0);
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLOCK_50);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_addr", int'(ram_addr), 0);
        end

        // Single dark pixel at the far corner.
        img[16383] = 8'd0;
        hits_last_pix = 0;
        run_box(127, 127, 127, 127, 0);
        chk("lit_pix_fg", int'(fg_count), 1);
        chk("lit_pix_area", int'(area), 1);
        chk("lit_pix_shape", int'(shape), 1);
        chk("lit_pix_reads", hits_last_pix, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
